// File: rtl/mem_access_ctrl_if.sv
// Memory-stage <-> controller <-> data-bus signal bundle.
// The controller uses the slave view; the pipeline/bus model uses the master view.
interface mem_access_ctrl_if;
    logic        m_valid;
    logic        m_is_load;
    logic        m_is_store;
    logic [31:0] m_addr;
    logic [1:0]  m_size;
    logic        m_unsigned;
    logic [31:0] m_wdata;
    logic        m_advance;
    logic [31:0] m_rdata;
    logic        m_stall;
    logic        m_misalign;
    logic        dreq_valid;
    logic [31:0] dreq_addr;
    logic [1:0]  dreq_size;
    logic [3:0]  dreq_strobe;
    logic [31:0] dreq_data;
    logic        dresp_addr_ok;
    logic        dresp_data_ok;
    logic [31:0] dresp_data;

    modport slave (
        input  m_valid, m_is_load, m_is_store, m_addr, m_size, m_unsigned,
               m_wdata, m_advance, dresp_addr_ok, dresp_data_ok, dresp_data,
        output m_rdata, m_stall, m_misalign,
               dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data
    );

    modport master (
        output m_valid, m_is_load, m_is_store, m_addr, m_size, m_unsigned,
               m_wdata, m_advance, dresp_addr_ok, dresp_data_ok, dresp_data,
        input  m_rdata, m_stall, m_misalign,
               dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Memory-stage load/store controller: issues one data-bus request at a time,
// aligns store data, and extracts/extends load results.
module mem_access_ctrl (
    input  logic             clk,
    input  logic             reset,
    mem_access_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  size_q, size_d;
    logic [3:0]  strobe_q, strobe_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  off_q, off_d;
    logic        uns_q, uns_d;
    logic        load_q, load_d;
    logic [31:0] rdata_q, rdata_d;

    logic        access_s;
    logic        misaligned_s;
    logic        acc_s;
    logic [1:0]  eff_size_s;
    logic [3:0]  req_strobe_s;
    logic [31:0] req_data_s;

    // Shift the addressed lane down, truncate to the access size, then extend.
    function automatic logic [31:0] load_extend(input logic [31:0] raw,
                                                input logic [1:0]  off,
                                                input logic [1:0]  size,
                                                input logic        uns);
        logic [31:0] sh;
        logic [31:0] res;
        sh = raw >> {off, 3'b000};
        case (size)
            2'b00:   res = uns ? {24'h000000, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
            2'b01:   res = uns ? {16'h0000, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: res = sh;
        endcase
        return res;
    endfunction

    assign eff_size_s   = (bus.m_size == 2'b11) ? 2'b10 : bus.m_size;
    assign access_s     = bus.m_valid & (bus.m_is_load | bus.m_is_store);
    assign misaligned_s = ((eff_size_s == 2'b01) & bus.m_addr[0]) |
                          ((eff_size_s == 2'b10) & (bus.m_addr[1:0] != 2'b00));
    assign acc_s        = access_s & ~misaligned_s;

    // Store lane strobe and replicated data; loads (which win over stores) carry neither.
    always_comb begin
        req_strobe_s = 4'b0000;
        req_data_s   = 32'h0000_0000;
        if (bus.m_is_load) begin
            req_strobe_s = 4'b0000;
            req_data_s   = 32'h0000_0000;
        end else begin
            case (eff_size_s)
                2'b00: begin
                    req_strobe_s = 4'b0001 << bus.m_addr[1:0];
                    req_data_s   = {4{bus.m_wdata[7:0]}};
                end
                2'b01: begin
                    req_strobe_s = 4'b0011 << bus.m_addr[1:0];
                    req_data_s   = {2{bus.m_wdata[15:0]}};
                end
                default: begin
                    req_strobe_s = 4'b1111;
                    req_data_s   = bus.m_wdata;
                end
            endcase
        end
    end

    // Next-state and register-update logic for the request FSM.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        size_d   = size_q;
        strobe_d = strobe_q;
        wdata_d  = wdata_q;
        off_d    = off_q;
        uns_d    = uns_q;
        load_d   = load_q;
        rdata_d  = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (acc_s) begin
                    state_d  = ST_REQ;
                    addr_d   = {bus.m_addr[31:2], 2'b00};
                    size_d   = eff_size_s;
                    strobe_d = req_strobe_s;
                    wdata_d  = req_data_s;
                    off_d    = bus.m_addr[1:0];
                    uns_d    = bus.m_unsigned;
                    load_d   = bus.m_is_load;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                // A data_ok seen before the address is accepted belongs to no request of ours.
                if (bus.dresp_addr_ok && bus.dresp_data_ok) begin
                    state_d = ST_DONE;
                    rdata_d = load_q ? load_extend(bus.dresp_data, off_q, size_q, uns_q) : rdata_q;
                end else if (bus.dresp_addr_ok) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (bus.dresp_data_ok) begin
                    state_d = ST_DONE;
                    rdata_d = load_q ? load_extend(bus.dresp_data, off_q, size_q, uns_q) : rdata_q;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_DONE: begin
                if (bus.m_advance) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and latched request/result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            addr_q   <= 32'h0000_0000;
            size_q   <= 2'b00;
            strobe_q <= 4'b0000;
            wdata_q  <= 32'h0000_0000;
            off_q    <= 2'b00;
            uns_q    <= 1'b0;
            load_q   <= 1'b0;
            rdata_q  <= 32'h0000_0000;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            size_q   <= size_d;
            strobe_q <= strobe_d;
            wdata_q  <= wdata_d;
            off_q    <= off_d;
            uns_q    <= uns_d;
            load_q   <= load_d;
            rdata_q  <= rdata_d;
        end
    end

    assign bus.dreq_valid  = (state_q == ST_REQ);
    assign bus.dreq_addr   = addr_q;
    assign bus.dreq_size   = size_q;
    assign bus.dreq_strobe = strobe_q;
    assign bus.dreq_data   = wdata_q;
    assign bus.m_rdata     = rdata_q;
    assign bus.m_stall     = (state_q == ST_REQ) | (state_q == ST_WAIT) |
                             ((state_q == ST_IDLE) & acc_s);
    assign bus.m_misalign  = (state_q == ST_IDLE) & access_s & misaligned_s;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed vector table, multi-cycle
// corner sequences, and random transactions against a byte-level reference model.
module tb_mem_access_ctrl;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    logic [31:0] m_rd;

    mem_access_ctrl_if bus ();

    mem_access_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        v;
        logic        ld;
        logic        st;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] wdata;
        logic [31:0] rbus;
        logic        e_stall;
        logic        e_mis;
        logic [3:0]  e_strb;
        logic [31:0] e_data;
        logic [1:0]  e_dsize;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t tv [14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic v, input logic ld, input logic st, input logic [31:0] addr,
                         input logic [1:0] size, input logic uns, input logic [31:0] wdata);
        bus.m_valid    = v;
        bus.m_is_load  = ld;
        bus.m_is_store = st;
        bus.m_addr     = addr;
        bus.m_size     = size;
        bus.m_unsigned = uns;
        bus.m_wdata    = wdata;
    endtask

    // Drives the bus side from the first REQ cycle through DONE and the advance.
    // ad = REQ cycles before addr_ok, dd = WAIT cycles (0: data_ok with addr_ok), hold = DONE cycles before advance.
    task automatic run_bus(input logic [31:0] e_addr, input logic [3:0] e_strb, input logic [31:0] e_data,
                           input logic [1:0] e_dsize, input logic [31:0] rbus, input int ad, input int dd,
                           input int hold, input logic [31:0] e_rdata);
        for (int k = 0; k <= ad; k++) begin
            bus.dresp_addr_ok = (k == ad);
            bus.dresp_data_ok = (k == ad) ? (dd == 0) : 1'($urandom_range(0, 1));
            bus.dresp_data    = (k == ad && dd == 0) ? rbus : $urandom;
            #2;
            chk("req_valid", {31'h0, bus.dreq_valid}, 32'h1);
            chk("req_addr", bus.dreq_addr, e_addr);
            chk("req_strobe", {28'h0, bus.dreq_strobe}, {28'h0, e_strb});
            chk("req_data", bus.dreq_data, e_data);
            chk("req_size", {30'h0, bus.dreq_size}, {30'h0, e_dsize});
            chk("req_stall", {31'h0, bus.m_stall}, 32'h1);
            step();
        end
        bus.dresp_addr_ok = 1'b0;
        bus.dresp_data_ok = 1'b0;
        for (int k = 1; k <= dd; k++) begin
            bus.dresp_data_ok = (k == dd);
            bus.dresp_data    = (k == dd) ? rbus : $urandom;
            #2;
            chk("wait_valid", {31'h0, bus.dreq_valid}, 32'h0);
            chk("wait_stall", {31'h0, bus.m_stall}, 32'h1);
            step();
        end
        for (int h = 0; h <= hold; h++) begin
            bus.m_advance     = (h == hold);
            bus.dresp_data_ok = 1'($urandom_range(0, 1));
            bus.dresp_data    = $urandom;
            #2;
            chk("done_stall", {31'h0, bus.m_stall}, 32'h0);
            chk("done_valid", {31'h0, bus.dreq_valid}, 32'h0);
            chk("done_rdata", bus.m_rdata, e_rdata);
            step();
        end
        bus.m_advance     = 1'b0;
        bus.dresp_data_ok = 1'b0;
    endtask

    task automatic check_all_reset();
        chk("rst_valid", {31'h0, bus.dreq_valid}, 32'h0);
        chk("rst_addr", bus.dreq_addr, 32'h0);
        chk("rst_size", {30'h0, bus.dreq_size}, 32'h0);
        chk("rst_strobe", {28'h0, bus.dreq_strobe}, 32'h0);
        chk("rst_data", bus.dreq_data, 32'h0);
        chk("rst_rdata", bus.m_rdata, 32'h0);
        chk("rst_stall", {31'h0, bus.m_stall}, 32'h0);
        chk("rst_misalign", {31'h0, bus.m_misalign}, 32'h0);
    endtask

    initial begin
        logic        v, ld, st, uns, acc, mis;
        logic [31:0] addr, wdata, rbus, sh, mask, val, e_data;
        logic [1:0]  size, dsize;
        logic [3:0]  strb;
        int          n, off, tmp;

        total = 0;
        bad   = 0;
        reset = 1'b1;
        issue(1'b0, 1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 32'h0);
        bus.m_advance     = 1'b0;
        bus.dresp_addr_ok = 1'b0;
        bus.dresp_data_ok = 1'b0;
        bus.dresp_data    = 32'h0;
        step();
        step();
        check_all_reset();
        reset = 1'b0;

        tv[0]  = '{1'b1, 1'b1, 1'b0, 32'h100, 2'b10, 1'b0, 32'h0,        32'h8765_4321, 1'b1, 1'b0, 4'b0000, 32'h0,         2'b10, 32'h8765_4321};
        tv[1]  = '{1'b1, 1'b0, 1'b1, 32'h202, 2'b01, 1'b0, 32'h0000_BEEF, 32'hFFFF_FFFF, 1'b1, 1'b0, 4'b1100, 32'hBEEF_BEEF, 2'b01, 32'h8765_4321};
        tv[2]  = '{1'b1, 1'b1, 1'b0, 32'h101, 2'b10, 1'b0, 32'h0,        32'h0,         1'b0, 1'b1, 4'b0000, 32'h0,         2'b00, 32'h8765_4321};
        tv[3]  = '{1'b1, 1'b1, 1'b0, 32'h103, 2'b01, 1'b0, 32'h0,        32'h0,         1'b0, 1'b1, 4'b0000, 32'h0,         2'b00, 32'h8765_4321};
        tv[4]  = '{1'b1, 1'b0, 1'b1, 32'h103, 2'b00, 1'b0, 32'h0000_00A5, 32'h0,         1'b1, 1'b0, 4'b1000, 32'hA5A5_A5A5, 2'b00, 32'h8765_4321};
        tv[5]  = '{1'b1, 1'b1, 1'b0, 32'h102, 2'b00, 1'b1, 32'h0,        32'h11C2_3344, 1'b1, 1'b0, 4'b0000, 32'h0,         2'b00, 32'h0000_00C2};
        tv[6]  = '{1'b1, 1'b1, 1'b0, 32'h102, 2'b01, 1'b0, 32'h0,        32'h9ABC_0000, 1'b1, 1'b0, 4'b0000, 32'h0,         2'b01, 32'hFFFF_9ABC};
        tv[7]  = '{1'b1, 1'b1, 1'b0, 32'h100, 2'b01, 1'b1, 32'h0,        32'h1234_8765, 1'b1, 1'b0, 4'b0000, 32'h0,         2'b01, 32'h0000_8765};
        tv[8]  = '{1'b1, 1'b1, 1'b1, 32'h104, 2'b10, 1'b0, 32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1, 1'b0, 4'b0000, 32'h0,         2'b10, 32'h0BAD_F00D};
        tv[9]  = '{1'b0, 1'b1, 1'b0, 32'h100, 2'b10, 1'b0, 32'h0,        32'h0,         1'b0, 1'b0, 4'b0000, 32'h0,         2'b00, 32'h0BAD_F00D};
        tv[10] = '{1'b1, 1'b0, 1'b0, 32'h101, 2'b10, 1'b0, 32'h0,        32'h0,         1'b0, 1'b0, 4'b0000, 32'h0,         2'b00, 32'h0BAD_F00D};
        tv[11] = '{1'b1, 1'b0, 1'b1, 32'h108, 2'b11, 1'b0, 32'h0102_0304, 32'h0,         1'b1, 1'b0, 4'b1111, 32'h0102_0304, 2'b10, 32'h0BAD_F00D};
        tv[12] = '{1'b1, 1'b1, 1'b0, 32'h10A, 2'b11, 1'b0, 32'h0,        32'h0,         1'b0, 1'b1, 4'b0000, 32'h0,         2'b00, 32'h0BAD_F00D};
        tv[13] = '{1'b1, 1'b0, 1'b1, 32'h101, 2'b00, 1'b0, 32'h1234_5677, 32'h0,         1'b1, 1'b0, 4'b0010, 32'h7777_7777, 2'b00, 32'h0BAD_F00D};

        for (int i = 0; i < 14; i++) begin
            issue(tv[i].v, tv[i].ld, tv[i].st, tv[i].addr, tv[i].size, tv[i].uns, tv[i].wdata);
            #2;
            chk("tv_stall", {31'h0, bus.m_stall}, {31'h0, tv[i].e_stall});
            chk("tv_misalign", {31'h0, bus.m_misalign}, {31'h0, tv[i].e_mis});
            step();
            if (tv[i].e_stall) begin
                run_bus(tv[i].addr & 32'hFFFF_FFFC, tv[i].e_strb, tv[i].e_data, tv[i].e_dsize,
                        tv[i].rbus, 0, 0, 0, tv[i].e_rdata);
            end else begin
                chk("tv_noreq", {31'h0, bus.dreq_valid}, 32'h0);
                chk("tv_rdata_hold", bus.m_rdata, tv[i].e_rdata);
            end
            bus.m_valid = 1'b0;
        end

        // Split handshake, signed byte at offset 3: REQ, WAIT x3, DONE.
        issue(1'b1, 1'b1, 1'b0, 32'h103, 2'b00, 1'b0, 32'h0);
        #2;
        chk("split_issue_stall", {31'h0, bus.m_stall}, 32'h1);
        step();
        run_bus(32'h100, 4'b0000, 32'h0, 2'b00, 32'h8012_3456, 0, 3, 0, 32'hFFFF_FF80);
        bus.m_valid = 1'b0;

        // Store with addr_ok held off two cycles; early data_ok must be ignored.
        issue(1'b1, 1'b0, 1'b1, 32'h300, 2'b10, 1'b0, 32'hCAFE_F00D);
        #2;
        step();
        run_bus(32'h300, 4'b1111, 32'hCAFE_F00D, 2'b10, 32'h0, 2, 0, 0, 32'hFFFF_FF80);
        bus.m_valid = 1'b0;

        // DONE held three cycles, then a new access must be taken straight from IDLE.
        issue(1'b1, 1'b1, 1'b0, 32'h500, 2'b10, 1'b0, 32'h0);
        #2;
        step();
        run_bus(32'h500, 4'b0000, 32'h0, 2'b10, 32'h55AA_33CC, 0, 1, 3, 32'h55AA_33CC);
        issue(1'b1, 1'b1, 1'b0, 32'h501, 2'b00, 1'b0, 32'h0);
        #2;
        chk("after_done_idle_stall", {31'h0, bus.m_stall}, 32'h1);
        step();
        run_bus(32'h500, 4'b0000, 32'h0, 2'b00, 32'h0000_7F00, 1, 0, 0, 32'h0000_007F);
        bus.m_valid = 1'b0;

        // Reset while waiting for data; the late data_ok must be dropped.
        issue(1'b1, 1'b1, 1'b0, 32'h400, 2'b10, 1'b0, 32'h0);
        #2;
        step();
        bus.dresp_addr_ok = 1'b1;
        step();
        bus.dresp_addr_ok = 1'b0;
        bus.m_valid       = 1'b0;
        #2;
        chk("pre_reset_wait_stall", {31'h0, bus.m_stall}, 32'h1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_all_reset();
        bus.dresp_data_ok = 1'b1;
        bus.dresp_data    = 32'h0000_1234;
        step();
        bus.dresp_data_ok = 1'b0;
        chk("late_dataok_rdata", bus.m_rdata, 32'h0);
        chk("late_dataok_stall", {31'h0, bus.m_stall}, 32'h0);
        chk("late_dataok_valid", {31'h0, bus.dreq_valid}, 32'h0);

        // Random transactions against a byte-lane reference model.
        m_rd = 32'h0;
        for (int t = 0; t < 300; t++) begin
            v     = ($urandom_range(0, 9) != 0);
            tmp   = $urandom_range(0, 3);
            ld    = (tmp == 1) || (tmp == 3);
            st    = (tmp == 2) || (tmp == 3);
            addr  = $urandom;
            size  = 2'($urandom_range(0, 3));
            uns   = 1'($urandom_range(0, 1));
            wdata = $urandom;
            rbus  = $urandom;
            n     = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
            off   = int'(addr % 4);
            mis   = v && (ld || st) && ((addr % n) != 0);
            acc   = v && (ld || st) && ((addr % n) == 0);
            issue(v, ld, st, addr, size, uns, wdata);
            #2;
            chk("rnd_stall", {31'h0, bus.m_stall}, {31'h0, acc});
            chk("rnd_misalign", {31'h0, bus.m_misalign}, {31'h0, mis});
            step();
            if (acc) begin
                dsize = (n == 1) ? 2'b00 : (n == 2) ? 2'b01 : 2'b10;
                if (ld) begin
                    strb   = 4'b0000;
                    e_data = 32'h0;
                    sh     = rbus >> (8 * off);
                    mask   = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
                    val    = sh & mask;
                    if (!uns && n < 4 && val[8 * n - 1]) begin
                        val = val | ~mask;
                    end
                    m_rd = val;
                end else begin
                    tmp    = ((1 << n) - 1) << off;
                    strb   = tmp[3:0];
                    e_data = (n == 1) ? wdata[7:0] * 32'h0101_0101 :
                             (n == 2) ? wdata[15:0] * 32'h0001_0001 : wdata;
                end
                run_bus(addr & 32'hFFFF_FFFC, strb, e_data, dsize, rbus,
                        $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), m_rd);
            end else begin
                chk("rnd_noreq", {31'h0, bus.dreq_valid}, 32'h0);
                chk("rnd_rdata_hold", bus.m_rdata, m_rd);
            end
            bus.m_valid = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 The block SHALL have exactly one clock and a synchronous, active-high reset; ports SHALL be as listed below.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 m_valid  in  1  memory stage holds a valid instruction.
REQ-005 m_is_load / m_is_store  in  1 each  instruction is a load / store.
REQ-006 m_addr  in  32  byte address; m_size  in  2  00 byte, 01 half, 10 word, 11 treated as word.
REQ-007 m_unsigned  in  1  zero-extend the load result (1) or sign-extend it (0).
REQ-008 m_wdata  in  32  store data, right-aligned.
REQ-009 m_advance  in  1  pipeline moves the memory stage forward this cycle.
REQ-010 dreq_valid  out  1; dreq_addr  out  32; dreq_size  out  2; dreq_strobe  out  4; dreq_data  out  32  data-bus request.
REQ-011 dresp_addr_ok / dresp_data_ok  in  1 each; dresp_data  in  32  data-bus response.
REQ-012 m_rdata  out  32  extended load result; m_stall  out  1  freeze the pipeline; m_misalign  out  1  address exception.

Function
REQ-013 The FSM SHALL have the states IDLE, REQ, WAIT and DONE.
REQ-014 Access condition (acc): m_valid & (m_is_load | m_is_store) & aligned.
- Half accesses are misaligned if addr[0]=1.
- Word accesses are misaligned if addr[1:0]!=0.
- If both load and store are asserted, load SHALL win.
REQ-015 IDLE, acc=1: latch the request fields, go to REQ next cycle, m_stall=1.
- Latched addr is {m_addr[31:2],2'b00}; latched size and strobe come from m_size.
REQ-016 IDLE, misaligned access: m_misalign=1 combinationally, m_stall=0, no bus request, stay IDLE.
REQ-017 Strobe for stores: byte 0001<<addr[1:0]; half 0011<<addr[1:0]; word 1111. Loads SHALL use strobe 0000.
REQ-018 dreq_data for stores: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word wdata.
REQ-019 REQ: dreq_valid=1 with the latched fields, which stay stable until addr_ok.
- addr_ok & data_ok in the same cycle: go to DONE.
- addr_ok only: go to WAIT.
- data_ok without addr_ok: ignored.
REQ-020 WAIT: dreq_valid=0; go to DONE on data_ok.
REQ-021 On the data_ok cycle of a load, m_rdata SHALL register the result: dresp_data >> (8*addr[1:0]), truncated to the size, then sign- or zero-extended. Stores SHALL leave m_rdata unchanged.
REQ-022 m_stall SHALL be 1 in REQ and WAIT, 0 in DONE, and 0 in IDLE unless acc=1.
REQ-023 DONE: go to IDLE when m_advance=1, otherwise hold DONE; no new request SHALL be issued from DONE.
REQ-024 data_ok in IDLE or DONE SHALL be ignored.
REQ-025 Minimum latency SHALL be 2 cycles: IDLE issue, REQ with addr_ok & data_ok, result visible in DONE.
REQ-026 There SHALL be at most one outstanding bus transaction.

Reset
REQ-027 On reset: state=IDLE; dreq_valid=0, dreq_addr=0, dreq_size=0, dreq_strobe=0, dreq_data=0, m_rdata=0, m_stall=0, m_misalign=0.
REQ-028 Reset in REQ or WAIT SHALL abandon the transaction. Any data_ok that arrives afterwards SHALL NOT update m_rdata.

Verification
REQ-029 Load word with single-cycle response: addr=0x100, size=10; addr_ok=data_ok=1 in the first REQ cycle, dresp_data=0x8765_4321.
- Required: dreq_valid high for 1 cycle with dreq_addr=0x100 and strobe=0000.
- Required: m_rdata=0x8765_4321 in DONE; m_stall 1,1 then 0.
REQ-030 Split handshake: LB signed, addr=0x103; addr_ok on cycle 2; data_ok on cycle 5 with data 0x80xx_xxxx.
- Required: state sequence REQ,WAIT,WAIT,WAIT,DONE; m_rdata=0xFFFF_FF80; m_stall=1 throughout.
REQ-031 SH at addr=0x202 with wdata=0x0000_BEEF.
- Required: dreq_strobe=1100, dreq_data=0xBEEF_BEEF, dreq_addr=0x200; m_rdata unchanged.
REQ-032 LW at addr=0x101.
- Required: m_misalign=1 and m_stall=0 the same cycle; dreq_valid stays 0.
REQ-033 Reset asserted in WAIT, then data_ok=1 with data 0x1234.
- Required: IDLE after reset; all outputs at reset values; m_rdata stays 0.
REQ-034 DONE with m_advance=0 for 3 cycles, then m_advance=1.
- Required: DONE and m_rdata held for 3 cycles; m_stall=0 throughout; no dreq_valid; IDLE on the next cycle.
